// File: rtl/imem_loader.sv
// Byte-stream program loader: assembles length-prefixed, checksummed little-endian words
// into the instruction memory write port and releases the core once a load verifies.
module imem_loader #(
   parameter int unsigned ADDR_W = 11,
   parameter int unsigned DEPTH  = 2048
) (
   input  logic              w_clk,
   input  logic              w_rst_n,
   input  logic              w_start,
   input  logic              w_bvalid,
   input  logic [7:0]        w_bdata,
   output logic              r_bready,
   output logic [ADDR_W-1:0] r_maddr,
   output logic              r_mwe,
   output logic [31:0]       r_mdin,
   output logic              r_hold,
   output logic              r_done,
   output logic              r_err,
   output logic [ADDR_W:0]   r_wcount
);

   typedef enum logic [2:0] {
      StIdle, StLen0, StLen1, StData, StWrite, StCsum, StDone, StErr
   } state_e;

   localparam logic [15:0]       MaxLen   = 16'(DEPTH);
   localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

   state_e          state_q;
   logic [7:0]      len_lo_q;
   logic [ADDR_W:0] len_q;
   logic [23:0]     shift_q;
   logic [1:0]      bcnt_q;
   logic [7:0]      sum_q;

   logic [15:0]     len_in;
   logic [ADDR_W:0] wcount_inc;
   logic            take;

   assign len_in     = {w_bdata, len_lo_q};
   assign wcount_inc = r_wcount + 1'b1;
   assign take       = w_bvalid & r_bready;

   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         state_q  <= StIdle;
         len_lo_q <= '0;
         len_q    <= '0;
         shift_q  <= '0;
         bcnt_q   <= '0;
         sum_q    <= '0;
         r_bready <= 1'b0;
         r_maddr  <= '0;
         r_mwe    <= 1'b0;
         r_mdin   <= '0;
         r_hold   <= 1'b1;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
         r_wcount <= '0;
      end else begin
         r_mwe <= 1'b0;
         unique case (state_q)
            StIdle, StDone, StErr: begin
               if (w_start) begin
                  state_q  <= StLen0;
                  r_bready <= 1'b1;
                  r_hold   <= 1'b1;
                  r_done   <= 1'b0;
                  r_err    <= 1'b0;
                  r_wcount <= '0;
                  r_maddr  <= '0;
                  sum_q    <= '0;
                  bcnt_q   <= '0;
               end
            end
            StLen0: begin
               if (take) begin
                  len_lo_q <= w_bdata;
                  state_q  <= StLen1;
               end
            end
            StLen1: begin
               if (take) begin
                  if (len_in > MaxLen) begin
                     state_q  <= StErr;
                     r_err    <= 1'b1;
                     r_bready <= 1'b0;
                  end else if (len_in == 16'd0) begin
                     state_q <= StCsum;
                  end else begin
                     len_q   <= len_in[ADDR_W:0];
                     state_q <= StData;
                  end
               end
            end
            StData: begin
               if (take) begin
                  sum_q  <= sum_q + w_bdata;
                  bcnt_q <= bcnt_q + 2'd1;
                  // First byte lands in bits [7:0]: shift in from the top.
                  if (bcnt_q == 2'd3) begin
                     r_mdin   <= {w_bdata, shift_q};
                     r_mwe    <= 1'b1;
                     r_bready <= 1'b0;
                     state_q  <= StWrite;
                  end else begin
                     shift_q <= {w_bdata, shift_q[23:8]};
                  end
               end
            end
            StWrite: begin
               r_wcount <= wcount_inc;
               if (r_maddr != LastAddr) r_maddr <= r_maddr + 1'b1;
               r_bready <= 1'b1;
               state_q  <= (wcount_inc == len_q) ? StCsum : StData;
            end
            StCsum: begin
               if (take) begin
                  r_bready <= 1'b0;
                  if (w_bdata == sum_q) begin
                     state_q <= StDone;
                     r_hold  <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     state_q <= StErr;
                     r_err   <= 1'b1;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table of load scenarios plus random loads, checked against a
// stream-parsing reference model; hand sequences cover restart collisions and async reset.
module tb_imem_loader;

   logic        w_clk = 1'b0;
   logic        w_rst_n;
   logic        w_start;
   logic        w_bvalid;
   logic [7:0]  w_bdata;
   logic        r_bready;
   logic [10:0] r_maddr;
   logic        r_mwe;
   logic [31:0] r_mdin;
   logic        r_hold;
   logic        r_done;
   logic        r_err;
   logic [11:0] r_wcount;

   imem_loader #(.ADDR_W(11), .DEPTH(2048)) dut (
      .w_clk    (w_clk),
      .w_rst_n  (w_rst_n),
      .w_start  (w_start),
      .w_bvalid (w_bvalid),
      .w_bdata  (w_bdata),
      .r_bready (r_bready),
      .r_maddr  (r_maddr),
      .r_mwe    (r_mwe),
      .r_mdin   (r_mdin),
      .r_hold   (r_hold),
      .r_done   (r_done),
      .r_err    (r_err),
      .r_wcount (r_wcount)
   );

   always #5 w_clk = ~w_clk;

   typedef struct {
      int         len_field;
      int         kind;
      logic [7:0] csum_xor;
      int         gap;
      bit         exp_done;
   } vec_t;

   int          vectors = 0;
   int          miscompares = 0;
   logic [7:0]  stream[$];
   logic [31:0] exp_words[$];
   logic [10:0] cap_addr[$];
   logic [31:0] cap_data[$];
   bit          m_done;
   int          m_wcount;
   int          m_nsend;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Every cycle with a write strobe is one captured memory write.
   always @(negedge w_clk) begin
      if (w_rst_n === 1'b1 && r_mwe === 1'b1) begin
         cap_addr.push_back(r_maddr);
         cap_data.push_back(r_mdin);
         check("bready_during_write", 32'(r_bready), 32'd0);
      end
   end

   task automatic build(input int len_field, input int kind, input logic [7:0] csum_xor);
      logic [31:0] w;
      logic [7:0]  cs;
      logic [15:0] lf;
      lf = 16'(len_field);
      stream.delete();
      stream.push_back(lf[7:0]);
      stream.push_back(lf[15:8]);
      if (len_field <= 2048) begin
         cs = 8'd0;
         for (int i = 0; i < len_field; i++) begin
            case (kind)
               0:       w = 32'(i + 1);
               1:       w = $urandom;
               2:       w = 32'h1234_5678;
               default: w = 32'(i);
            endcase
            for (int b = 0; b < 4; b++) begin
               stream.push_back(w[8*b +: 8]);
               cs = cs + w[8*b +: 8];
            end
         end
         stream.push_back(cs ^ csum_xor);
      end
   endtask

   // Reference: parse the byte stream by the format rules.
   task automatic model();
      int n;
      int sum;
      n = int'(stream[0]) + 256 * int'(stream[1]);
      exp_words.delete();
      if (n > 2048) begin
         m_done = 1'b0; m_wcount = 0; m_nsend = 2;
         return;
      end
      sum = 0;
      for (int i = 0; i < n; i++) begin
         int p;
         p = 2 + 4 * i;
         exp_words.push_back({stream[p+3], stream[p+2], stream[p+1], stream[p]});
         sum = sum + int'(stream[p]) + int'(stream[p+1]) + int'(stream[p+2]) + int'(stream[p+3]);
      end
      m_nsend = 2 + 4 * n + 1;
      m_wcount = n;
      m_done = (int'(stream[m_nsend-1]) == sum % 256);
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int t;
      while ($urandom_range(99) < gap) begin
         w_bvalid = 1'b0;
         w_bdata  = 8'($urandom);
         @(negedge w_clk);
      end
      w_bvalid = 1'b1;
      w_bdata  = b;
      t = 0;
      while (!r_bready && t < 50) begin
         @(negedge w_clk);
         t++;
      end
      if (!r_bready) begin
         check("byte_accept_timeout", 32'(r_bready), 32'd1);
         w_bvalid = 1'b0;
         return;
      end
      @(negedge w_clk);
      w_bvalid = 1'b0;
   endtask

   task automatic pulse_start();
      w_start = 1'b1;
      @(negedge w_clk);
      w_start = 1'b0;
   endtask

   task automatic run_load(input int len_field, input int kind, input logic [7:0] csum_xor,
                           input int gap, input bit do_start);
      build(len_field, kind, csum_xor);
      model();
      cap_addr.delete();
      cap_data.delete();
      if (do_start) pulse_start();
      for (int i = 0; i < m_nsend; i++) send_byte(stream[i], gap);
      repeat (2) @(negedge w_clk);
      check("write_count", 32'(cap_addr.size()), 32'(exp_words.size()));
      for (int i = 0; i < cap_addr.size() && i < exp_words.size(); i++) begin
         check("write_addr", 32'(cap_addr[i]), 32'(i));
         check("write_data", cap_data[i], exp_words[i]);
      end
      check("done", 32'(r_done), 32'(m_done));
      check("err", 32'(r_err), 32'(!m_done));
      check("hold", 32'(r_hold), 32'(!m_done));
      check("bready_idle", 32'(r_bready), 32'd0);
      check("wcount", 32'(r_wcount), 32'(m_wcount));
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t tv[9];
      int   t;
      tv[0] = '{1,     2, 8'h00, 0,  1'b1};
      tv[1] = '{3,     0, 8'h00, 40, 1'b1};
      tv[2] = '{1,     2, 8'h01, 0,  1'b0};
      tv[3] = '{2049,  0, 8'h00, 0,  1'b0};
      tv[4] = '{0,     0, 8'h00, 0,  1'b1};
      tv[5] = '{17,    1, 8'h00, 30, 1'b1};
      tv[6] = '{8,     1, 8'h80, 20, 1'b0};
      tv[7] = '{65535, 0, 8'h00, 0,  1'b0};
      tv[8] = '{2048,  3, 8'h00, 0,  1'b1};

      w_rst_n = 1'b0; w_start = 1'b0; w_bvalid = 1'b0; w_bdata = 8'h00;
      repeat (3) @(negedge w_clk);
      check("rst_hold", 32'(r_hold), 32'd1);
      check("rst_bready", 32'(r_bready), 32'd0);
      check("rst_mwe", 32'(r_mwe), 32'd0);
      check("rst_maddr", 32'(r_maddr), 32'd0);
      check("rst_mdin", r_mdin, 32'd0);
      check("rst_done", 32'(r_done), 32'd0);
      check("rst_err", 32'(r_err), 32'd0);
      check("rst_wcount", 32'(r_wcount), 32'd0);
      w_rst_n = 1'b1;
      @(negedge w_clk);

      for (int i = 0; i < 9; i++) begin
         run_load(tv[i].len_field, tv[i].kind, tv[i].csum_xor, tv[i].gap, 1'b1);
         check("table_done", 32'(r_done), 32'(tv[i].exp_done));
         if (tv[i].len_field == 2048) check("full_last_maddr", 32'(r_maddr), 32'd2047);
      end

      // In DONE: start and a valid byte together; the byte must not become len_lo.
      w_start = 1'b1; w_bvalid = 1'b1; w_bdata = 8'h05;
      @(negedge w_clk);
      w_start = 1'b0; w_bvalid = 1'b0;
      check("restart_bready", 32'(r_bready), 32'd1);
      check("restart_hold", 32'(r_hold), 32'd1);
      check("restart_done_clr", 32'(r_done), 32'd0);
      run_load(1, 2, 8'h00, 0, 1'b0);

      // Async reset while a write strobe is up.
      pulse_start();
      build(2, 1, 8'h00);
      for (int i = 0; i < 6; i++) send_byte(stream[i], 0);
      t = 0;
      while (!r_mwe && t < 20) begin
         @(negedge w_clk);
         t++;
      end
      check("mwe_before_reset", 32'(r_mwe), 32'd1);
      #2 w_rst_n = 1'b0;
      #1;
      check("async_mwe", 32'(r_mwe), 32'd0);
      check("async_hold", 32'(r_hold), 32'd1);
      check("async_bready", 32'(r_bready), 32'd0);
      check("async_done", 32'(r_done), 32'd0);
      check("async_wcount", 32'(r_wcount), 32'd0);
      @(negedge w_clk);
      w_rst_n = 1'b1;
      @(negedge w_clk);

      for (int i = 0; i < 6; i++) begin
         run_load($urandom_range(1, 40), 1,
                  ($urandom_range(1) == 1) ? 8'h00 : 8'($urandom_range(1, 255)), 35, 1'b1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
